// File: rtl/avr_timer.sv
// Memory-mapped AVR timer/counter: prescaled tick, compare/CTC, overflow and
// compare flags with interrupts, toggle output, and TEMP-based atomic 16-bit access.
module avr_timer #(
  parameter int          WIDTH = 16,
  parameter logic [15:0] BASE  = 16'h0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        wen,
  input  logic        ren,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        irq_ovf,
  output logic        irq_cmp,
  output logic        oc_out
);

  localparam bit              WIDE     = (WIDTH == 16);
  localparam logic [WIDTH-1:0] TCNT_MAX = {WIDTH{1'b1}};

  logic [2:0]       cs_r;
  logic             ctc_r;
  logic             ocen_r;
  logic             tov_r;
  logic             ocf_r;
  logic             toie_r;
  logic             ocie_r;
  logic [WIDTH-1:0] tcnt_r;
  logic [WIDTH-1:0] ocr_r;
  logic [7:0]       temp_r;
  logic [9:0]       presc_r;
  logic [7:0]       rdata_r;
  logic             sel_r;
  logic             oc_r;

  logic [15:0]      off_s;
  logic             hit_s;
  logic [2:0]       reg_s;
  logic             wr_s;
  logic             rd_s;
  logic             tick_s;
  logic             match_s;
  logic             tcnt_wr_s;
  logic             set_ocf_s;
  logic             set_tov_s;
  logic             presc_run_s;
  logic [WIDTH-1:0] load_s;
  logic [7:0]       tcnt_hi_s;
  logic [7:0]       ocr_hi_s;
  logic [7:0]       rd_mux_s;

  assign off_s = addr - BASE;
  assign hit_s = (off_s < 16'd7);
  assign reg_s = off_s[2:0];
  assign wr_s  = wen & hit_s;
  assign rd_s  = ren & hit_s;

  // Tick selection, event qualification and read-data multiplexing
  always_comb begin
    tick_s = 1'b0;
    case (cs_r)
      3'd1:    tick_s = 1'b1;
      3'd2:    tick_s = &presc_r[2:0];
      3'd3:    tick_s = &presc_r[5:0];
      3'd4:    tick_s = &presc_r[7:0];
      3'd5:    tick_s = &presc_r[9:0];
      default: tick_s = 1'b0;
    endcase

    presc_run_s = (cs_r >= 3'd2) && (cs_r <= 3'd5);
    match_s     = (tcnt_r == ocr_r);
    // A TCNT write in the same cycle overrides the tick entirely
    tcnt_wr_s   = wr_s && (reg_s == 3'd3);
    set_ocf_s   = tick_s && !tcnt_wr_s && match_s;
    set_tov_s   = tick_s && !tcnt_wr_s && !(ctc_r && match_s) && (tcnt_r == TCNT_MAX);

    load_s    = WIDE ? WIDTH'({temp_r, wdata}) : WIDTH'(wdata);
    tcnt_hi_s = 8'(16'(tcnt_r) >> 4'd8);
    ocr_hi_s  = 8'(16'(ocr_r) >> 4'd8);

    rd_mux_s = 8'h00;
    case (reg_s)
      3'd0:    rd_mux_s = {3'b000, ocen_r, ctc_r, cs_r};
      3'd1:    rd_mux_s = {6'b000000, ocf_r, tov_r};
      3'd2:    rd_mux_s = {6'b000000, ocie_r, toie_r};
      3'd3:    rd_mux_s = tcnt_r[7:0];
      3'd4:    rd_mux_s = WIDE ? temp_r : 8'h00;
      3'd5:    rd_mux_s = ocr_r[7:0];
      3'd6:    rd_mux_s = WIDE ? temp_r : 8'h00;
      default: rd_mux_s = 8'h00;
    endcase
  end

  // Register file, counter, flags and bus response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_r    <= 3'd0;
      ctc_r   <= 1'b0;
      ocen_r  <= 1'b0;
      tov_r   <= 1'b0;
      ocf_r   <= 1'b0;
      toie_r  <= 1'b0;
      ocie_r  <= 1'b0;
      tcnt_r  <= '0;
      ocr_r   <= '0;
      temp_r  <= 8'h00;
      presc_r <= 10'd0;
      rdata_r <= 8'h00;
      sel_r   <= 1'b0;
      oc_r    <= 1'b0;
    end else begin
      sel_r   <= hit_s;
      rdata_r <= hit_s ? rd_mux_s : 8'h00;

      if (wr_s && (reg_s == 3'd0)) begin
        cs_r    <= wdata[2:0];
        ctc_r   <= wdata[3];
        ocen_r  <= wdata[4];
        presc_r <= 10'd0;
      end else if (presc_run_s) begin
        presc_r <= presc_r + 10'd1;
      end

      if (wr_s && (reg_s == 3'd2)) begin
        toie_r <= wdata[0];
        ocie_r <= wdata[1];
      end

      // Set has priority over a write-1 clear in the same cycle
      tov_r <= (tov_r & ~(wr_s && (reg_s == 3'd1) && wdata[0])) | set_tov_s;
      ocf_r <= (ocf_r & ~(wr_s && (reg_s == 3'd1) && wdata[1])) | set_ocf_s;
      oc_r  <= oc_r ^ (set_ocf_s & ocen_r);

      if (WIDE && wr_s && ((reg_s == 3'd4) || (reg_s == 3'd6))) begin
        temp_r <= wdata;
      end else if (WIDE && rd_s && (reg_s == 3'd3)) begin
        temp_r <= tcnt_hi_s;
      end else if (WIDE && rd_s && (reg_s == 3'd5)) begin
        temp_r <= ocr_hi_s;
      end

      if (wr_s && (reg_s == 3'd5)) begin
        ocr_r <= load_s;
      end

      if (tcnt_wr_s) begin
        tcnt_r <= load_s;
      end else if (tick_s) begin
        if ((ctc_r && match_s) || (tcnt_r == TCNT_MAX)) begin
          tcnt_r <= '0;
        end else begin
          tcnt_r <= tcnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign rdata   = rdata_r;
  assign sel     = sel_r;
  assign oc_out  = oc_r;
  assign irq_ovf = tov_r & toie_r;
  assign irq_cmp = ocf_r & ocie_r;

endmodule

// File: tb/tb_avr_timer.sv
// Directed bench for avr_timer: a 16-bit and an 8-bit instance share one CPU bus;
// every expectation is a hand-computed constant.
module tb_avr_timer;

  localparam logic [15:0] B = 16'h0080;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [7:0]  wdata;

  logic [7:0]  rdata16, rdata8;
  logic        sel16, sel8;
  logic        irq_ovf16, irq_ovf8;
  logic        irq_cmp16, irq_cmp8;
  logic        oc16, oc8;

  int checks = 0;
  int fails  = 0;

  avr_timer #(.WIDTH(16), .BASE(B)) dut16 (
    .clk(clk), .reset(reset), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rdata16), .sel(sel16), .irq_ovf(irq_ovf16), .irq_cmp(irq_cmp16), .oc_out(oc16)
  );

  avr_timer #(.WIDTH(8), .BASE(B)) dut8 (
    .clk(clk), .reset(reset), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
    .rdata(rdata8), .sel(sel8), .irq_ovf(irq_ovf8), .irq_cmp(irq_cmp8), .oc_out(oc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each bus task starts at a negedge and consumes exactly one rising edge.
  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    addr  = B + 16'(off);
    wdata = d;
    wen   = 1'b1;
    @(negedge clk);
    wen   = 1'b0;
    addr  = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    addr = a;
    ren  = 1'b1;
    @(negedge clk);
    ren  = 1'b0;
    addr = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    addr  = 16'h0000;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rdata", 16'(rdata16), 16'h00);
    check("rst_sel", 16'(sel16), 16'h0);
    check("rst_oc", 16'(oc16), 16'h0);
    check("rst_irq_ovf", 16'(irq_ovf16), 16'h0);
    check("rst_irq_cmp", 16'(irq_cmp16), 16'h0);
    reset = 1'b0;

    // All seven offsets read back zero, sel only after in-window accesses
    for (int i = 0; i < 7; i++) begin
      rd(B + 16'(i));
      check("rd0_data", 16'(rdata16), 16'h00);
      check("rd0_sel", 16'(sel16), 16'h1);
    end
    idle(1);
    check("sel_idle", 16'(sel16), 16'h0);
    rd(B + 16'd7);
    check("sel_out_of_window", 16'(sel16), 16'h0);
    check("rdata_out_of_window", 16'(rdata16), 16'h00);

    // Overflow from 0xFFFE at CS=1
    wr(3'd2, 8'h01);
    wr(3'd4, 8'hFF);
    wr(3'd3, 8'hFE);
    wr(3'd0, 8'h01);
    check("ovf_after_tccr", 16'(irq_ovf16), 16'h0);
    idle(1);
    check("ovf_at_ffff", 16'(irq_ovf16), 16'h0);
    idle(1);
    check("ovf_set", 16'(irq_ovf16), 16'h1);
    rd(B + 16'd1);
    check("tifr_tov", 16'(rdata16), 16'h01);
    wr(3'd1, 8'h01);
    check("ovf_cleared", 16'(irq_ovf16), 16'h0);

    // CTC with OCR=3 at CS=2: match every 32 clocks
    wr(3'd0, 8'h00);
    wr(3'd4, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd6, 8'h00);
    wr(3'd5, 8'h03);
    wr(3'd1, 8'h03);
    wr(3'd2, 8'h02);
    check("cmp_idle", 16'(irq_cmp16), 16'h0);
    wr(3'd0, 8'h1A);
    idle(31);
    check("ctc_oc_before", 16'(oc16), 16'h0);
    check("ctc_cmp_before", 16'(irq_cmp16), 16'h0);
    idle(1);
    check("ctc_oc_first", 16'(oc16), 16'h1);
    check("ctc_cmp_first", 16'(irq_cmp16), 16'h1);
    rd(B + 16'd3);
    check("ctc_tcnt_wrapped", 16'(rdata16), 16'h00);
    wr(3'd1, 8'h02);
    check("ctc_cmp_cleared", 16'(irq_cmp16), 16'h0);
    idle(29);
    check("ctc_oc_hold", 16'(oc16), 16'h1);
    idle(1);
    check("ctc_oc_second", 16'(oc16), 16'h0);
    check("ctc_cmp_second", 16'(irq_cmp16), 16'h1);
    rd(B + 16'd1);
    check("ctc_no_tov", 16'(rdata16), 16'h02);

    // Atomic read while counting
    wr(3'd0, 8'h00);
    wr(3'd4, 8'h12);
    wr(3'd3, 8'hFF);
    wr(3'd0, 8'h01);
    rd(B + 16'd3);
    check("atomic_low", 16'(rdata16), 16'hFF);
    rd(B + 16'd4);
    check("atomic_high", 16'(rdata16), 16'h12);

    // Conflicts: write beats tick, flag set beats clear
    wr(3'd4, 8'hFF);
    wr(3'd3, 8'hFF);
    wr(3'd1, 8'h03);
    rd(B + 16'd1);
    check("set_beats_clear", 16'(rdata16), 16'h01);
    wr(3'd4, 8'hAB);
    wr(3'd3, 8'hCD);
    rd(B + 16'd3);
    check("write_beats_tick_lo", 16'(rdata16), 16'hCD);
    rd(B + 16'd4);
    check("write_beats_tick_hi", 16'(rdata16), 16'hAB);

    // Asynchronous reset mid-count
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_sel", 16'(sel16), 16'h0);
    check("async_rst_rdata", 16'(rdata16), 16'h00);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    rd(B + 16'd3);
    check("rst_tcnt_stays", 16'(rdata16), 16'h00);
    rd(B + 16'd0);
    check("rst_tccr", 16'(rdata16), 16'h00);

    // WIDTH=8 instance
    wr(3'd2, 8'h01);
    wr(3'd3, 8'hFF);
    wr(3'd0, 8'h01);
    check("w8_ovf_before", 16'(irq_ovf8), 16'h0);
    idle(1);
    check("w8_ovf_set", 16'(irq_ovf8), 16'h1);
    rd(B + 16'd3);
    check("w8_tcnt_wrapped", 16'(rdata8), 16'h00);
    rd(B + 16'd4);
    check("w8_high_reads0", 16'(rdata8), 16'h00);
    wr(3'd4, 8'h55);
    rd(B + 16'd4);
    check("w8_high_write_ignored", 16'(rdata8), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/avr_timer.md
# avr_timer

Parametrised memory-mapped timer/counter for the AVR SoC, the successor to the free-running 8-bit `tcnt1` counter in the IO space. It adds a 10-bit prescaler, a compare register, clear-on-compare (CTC) mode, overflow and compare flags with interrupt outputs, a compare-toggle output pin, and AVR-style atomic 16-bit access through a TEMP byte. It sits on the CPU data bus beside RAM. The SoC muxes `rdata` into `data_read` whenever `sel` is high.

## Interface
- `WIDTH`, 16, counter/compare width; legal values 8 or 16.
- `BASE`, 16'h0080, data-space address of register offset 0; the window is BASE..BASE+6.

- `clk` in 1 — system clock; all state on rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state.
- `addr` in 16 — CPU data address.
- `wen` in 1 — write strobe, same cycle as `addr`/`wdata`.
- `ren` in 1 — read strobe; gates read side effects.
- `wdata` in 8 — write data.
- `rdata` out 8 — registered read data.
- `sel` out 1 — registered; high the cycle after `addr` hits the window.
- `irq_ovf` out 1 — TOV & TOIE.
- `irq_cmp` out 1 — OCF & OCIE.
- `oc_out` out 1 — compare-match toggle output.

## Operation
- Register map, as offsets from BASE:
  - +0 TCCR: [2:0] CS, [3] CTC, [4] OCEN; [7:5] read 0.
  - +1 TIFR: [0] TOV, [1] OCF; write 1 clears a bit, write 0 has no effect.
  - +2 TIMSK: [0] TOIE, [1] OCIE.
  - +3 TCNT low, +4 TCNT high.
  - +5 OCR low, +6 OCR high.
- CS selects the tick rate:
  - 0 = stopped; 1 = every clk; 2 = /8; 3 = /64; 4 = /256; 5 = /1024; 6 and 7 = stopped.
  - Prescaler: 10-bit counter, increments every clk while CS is 2–5.
  - Tick when prescaler[k-1:0] is all ones, with k = 3, 6, 8, 10.
  - Any write to TCCR clears the prescaler.
- Behaviour on each tick:
  - Match condition: `match = (TCNT == OCR)`.
  - If match: set OCF; if OCEN, toggle `oc_out`.
  - If CTC && match: TCNT ← 0, TOV unchanged.
  - Else if TCNT == 2^WIDTH−1: TCNT ← 0, set TOV. This also applies in CTC when OCR < TCNT.
  - Else: TCNT ← TCNT+1.
- 16-bit access (WIDTH=16):
  - Write high byte (+4/+6): stores `wdata` into TEMP only.
  - Write low byte: loads `{TEMP, wdata}` into the register in one cycle.
  - Read low byte with `ren`: returns the low byte and latches the matching high byte into TEMP.
  - Read high byte: returns TEMP.
  - TCNT and OCR share one TEMP.
- With WIDTH=8: +4/+6 read 0 and writes to them are ignored; TEMP is unused.
- Addresses outside the window: no side effects; `sel` is low the next cycle.

## Timing
- Reset values: TCCR, TIFR, TIMSK, TCNT, OCR, TEMP, prescaler = 0; `rdata`=0, `sel`=0, `oc_out`=0, both irq outputs = 0.
- Reads: `addr` presented in cycle N → `rdata`/`sel` valid in cycle N+1.
  - `rdata` shows the pre-update register value sampled at edge N.
  - TEMP latching occurs at edge N.
- Writes take effect at the edge ending the `wen` cycle.
- The irq outputs are combinational from registered flags, so they rise the cycle after the causing tick.
- Simultaneous events:
  - TCNT write and tick in the same cycle: the write wins; no increment, no match evaluation.
  - Flag set and write-1-clear in the same cycle: the set wins.
  - OCR write and tick in the same cycle: match uses the old OCR.
  - TCCR write: the new CS applies from the next cycle; a tick in the write cycle uses the old CS.
- Asynchronous reset mid-count returns everything to reset values immediately. Counting resumes only after TCCR is written.

## Test plan
- Reset, then read all seven offsets → every byte 0; `sel`=1 only the cycle after each in-window access; a read at BASE+7 → `sel`=0.
- CS=1, TCNT=16'hFFFE via high-then-low writes → 2 cycles later TCNT=0, TOV=1; TOIE=1 → `irq_ovf`=1; write TIFR=1 → `irq_ovf`=0 next cycle.
- CS=2, CTC=1, OCEN=1, OCR=3:
  - Ticks arrive every 8 clks; TCNT cycles 0,1,2,3,0.
  - OCF sets and `oc_out` toggles once per 32 clks.
  - TOV never sets.
- Atomic read: TCNT=16'h12FF running at CS=1 → read low (returns FF), then read high → returns 12, not 13.
- Conflicts: flag set and TIFR clear in the same cycle → flag stays 1; TCNT write coincident with a tick → TCNT equals the written value.
- WIDTH=8 instance: CS=1, TCNT=8'hFF → TOV sets after one tick; +4 reads 0.
